int_ex_unit: RTL
================

// Module: int_ex_unit
// PURPOSE
// Integer execution unit: the consumer end of the reservation-station issue interface (*_rs2ex / stop_ex2rs).
// Executes RV64I OP/OP-IMM ALU ops in 1 cycle and MUL iteratively (radix-2, XLEN cycles).
// Drives the integer forwarding path (*_int2rs), which is also sampled by the ROB (*_int2rob).
// PARAMETERS
// XLEN      64   operand/result width
// TAG_W     6    width of ROB tag and rd tag
// PORTS
// clk            in   1      clock
// res            in   1      reset: one clock; reset is synchronous and active-high
// valid_rs2ex    in   1      issue request from RS
// opcode_rs2ex   in   7      RISC-V opcode
// funct3_rs2ex   in   3      funct3
// imm_rs2ex      in   12     I-imm; for R-type ID packs funct7 into imm[11:5]
// rs1_rs2ex      in   XLEN   operand 1
// rs2_rs2ex      in   XLEN   operand 2 (ignored for OP-IMM)
// rd_rs2ex       in   TAG_W  destination tag
// tag_rs2ex      in   TAG_W  ROB tag
// stop_ex2rs     out  1      unit busy; RS must not issue
// result_int2rs  out  XLEN   result
// valid_int2rs   out  1      result valid, exactly 1 cycle per op
// rd_int2rs      out  TAG_W  destination tag of result
// tag_int2rob    out  TAG_W  ROB tag of result
// exc_int2rob    out  1      illegal-instruction flag, qualified by valid_int2rs
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, counter 0. Reset during MUL aborts it; no result is emitted.
// - Accept at rising edge k iff valid_rs2ex && !stop_ex2rs. stop_ex2rs = (state==MUL), from a register only, never from inputs.
// - ALU op: registered at edge k; valid_int2rs=1 for the single cycle after edge k. Back-to-back issue every cycle is supported.
// - Decode: OP-IMM 0010011: ADDI SLTI SLTIU XORI ORI ANDI; SLLI/SRLI/SRAI use shamt=imm[5:0], SRAI iff imm[10].
// - Decode: OP 0110011 funct7=0000000/0100000: ADD/SUB (imm[10]), SLL SLT SLTU XOR SRL/SRA (imm[10]) OR AND. Shamt=rs2[5:0].
// - imm sign-extended to XLEN. SLT/SLTU result is 0/1 zero-extended. Add/sub wrap modulo 2^XLEN.
// - MUL (OP, funct7=0000001, funct3=000): low XLEN bits of rs1*rs2 (sign-agnostic).
//   Edge k: latch operands/rd/tag, cnt=XLEN-1, IDLE->MUL. Edges k+1..k+XLEN: one shift-add step each.
//   Edge k+XLEN (cnt==0): register result, MUL->IDLE. valid_int2rs=1 in cycle after edge k+XLEN.
//   stop_ex2rs=1 in cycles after edges k..k+XLEN-1; earliest next accept is edge k+XLEN+1.
// - Illegal (any other opcode, funct7 or M funct3): behaves as a 1-cycle op, result 0, exc_int2rob=1.
// - valid_int2rs=0 ⇒ result/rd/tag/exc hold their last value; consumers ignore them.
// - No backpressure on outputs: ROB and RS always sample valid_int2rs.
// - valid_rs2ex while stop_ex2rs=1: ignored, no state change; RS keeps the op.
// - Only IDLE and MUL states exist. An op accepted in IDLE never collides with a MUL completion.
// STRUCTURE
// - ex_pkg: XLEN default, OPC_OP/OPC_OP_IMM, funct3 enum (F3_ADD..F3_AND), FUNCT7_MULDIV, state enum {IDLE,MUL}.
// - Sub-module int_mul_iter: start/operands in, done pulse + product out, owns counter and shift registers.
// - Top level: combinational ALU, decode/illegal logic, output register, stop generation.
// TESTING
// - ADD rs1=5, rs2=-7 (OP, imm=0) at edge k -> cycle after k: valid=1, result=0xFFFF_FFFF_FFFF_FFFE, rd/tag echoed, exc=0.
// - SUB via imm[10]=1, rs1=3, rs2=10 -> -7. SRAI rs1=0x8000_0000_0000_0000, imm=0x43F -> all ones.
// - SLTU rs1=1, rs2=-1 -> 1; SLT with the same operands -> 0. Three back-to-back ALU ops -> three consecutive valid cycles.
// - MUL 7 x -3 at edge k -> stop=1 for 64 cycles, valid only in cycle after edge k+64, result=-21.
//   An op held on valid_rs2ex during the MUL is accepted at edge k+65.
// - MUL in flight, res=1 at edge k+10 -> stop=0 and valid=0 afterwards, no result ever emitted. Next ADD works normally.
// - opcode 0000011 or OP funct7=0000001 funct3=100 -> 1 cycle later: valid=1, exc_int2rob=1, result=0.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared constants and types for the integer execution unit.
// Combinational definitions only; no latency.
// No flow control here; consumed by int_ex_unit and int_mul_iter.
package ex_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int TAG_W_DEF = 6;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } funct3_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } ex_state_e;

endpackage

// File: rtl/int_mul_iter.sv
// Radix-2 shift-add multiplier producing the low XLEN bits of a*b.
// Latency: start edge plus XLEN step edges; product valid alongside done_o.
// No backpressure: caller must not pulse start_i while a multiply is active.
import ex_pkg::*;

module int_mul_iter #(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            res,
    input  logic            start_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] product_o
);

    localparam int CW = $clog2(XLEN);

    logic            active_q, active_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] acc_step;

    // Accumulator value after the current step; the last step's value is the product.
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o    = active_q && (cnt_q == '0);
    assign product_o = acc_step;

    // Next-state: load on start, otherwise one shift-add step per active cycle.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start_i) begin
            active_d = 1'b1;
            cnt_d    = CW'(XLEN - 1);
            acc_d    = '0;
            mcand_d  = a_i;
            mplier_d = b_i;
        end else if (active_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // State registers; reset aborts any multiply in flight.
    always_ff @(posedge clk) begin
        if (res) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/int_ex_unit.sv
// Integer execution unit: RV64I OP/OP-IMM ALU plus iterative MUL.
// Latency: ALU and illegal ops 1 cycle; MUL XLEN+1 cycles from accept to result.
// Backpressure: stop_ex2rs is high while a MUL is in flight; results are never stalled.
import ex_pkg::*;

module int_ex_unit #(
    parameter int XLEN  = XLEN_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             res,
    input  logic             valid_rs2ex,
    input  logic [6:0]       opcode_rs2ex,
    input  logic [2:0]       funct3_rs2ex,
    input  logic [11:0]      imm_rs2ex,
    input  logic [XLEN-1:0]  rs1_rs2ex,
    input  logic [XLEN-1:0]  rs2_rs2ex,
    input  logic [TAG_W-1:0] rd_rs2ex,
    input  logic [TAG_W-1:0] tag_rs2ex,
    output logic             stop_ex2rs,
    output logic [XLEN-1:0]  result_int2rs,
    output logic             valid_int2rs,
    output logic [TAG_W-1:0] rd_int2rs,
    output logic [TAG_W-1:0] tag_int2rob,
    output logic             exc_int2rob
);

    localparam int SHW = $clog2(XLEN);

    ex_state_e        state_q, state_d;
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [TAG_W-1:0] rd_q, rd_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             exc_q, exc_d;
    logic [TAG_W-1:0] mul_rd_q, mul_rd_d;
    logic [TAG_W-1:0] mul_tag_q, mul_tag_d;

    logic [XLEN-1:0]  imm_sext;
    logic [XLEN-1:0]  op_b;
    logic [SHW-1:0]   shamt;
    logic [6:0]       funct7;
    logic [XLEN-1:0]  alu_res;
    logic             illegal;
    logic             is_mul;
    logic             accept;
    logic             mul_done;
    logic [XLEN-1:0]  mul_product;

    assign imm_sext = {{(XLEN-12){imm_rs2ex[11]}}, imm_rs2ex};
    assign funct7   = imm_rs2ex[11:5];
    assign op_b     = (opcode_rs2ex == OPC_OP_IMM) ? imm_sext : rs2_rs2ex;
    assign shamt    = (opcode_rs2ex == OPC_OP_IMM) ? imm_rs2ex[SHW-1:0] : rs2_rs2ex[SHW-1:0];
    assign accept   = valid_rs2ex && (state_q == IDLE);

    assign stop_ex2rs    = (state_q == MUL);
    assign valid_int2rs  = valid_q;
    assign result_int2rs = result_q;
    assign rd_int2rs     = rd_q;
    assign tag_int2rob   = tag_q;
    assign exc_int2rob   = exc_q;

    // Decode and ALU; imm[10] selects SUB/SRA, shifts check the upper imm bits.
    always_comb begin
        alu_res = '0;
        illegal = 1'b0;
        is_mul  = 1'b0;
        if (opcode_rs2ex == OPC_OP && funct7 == FUNCT7_MULDIV) begin
            if (funct3_rs2ex == F3_ADD) is_mul  = 1'b1;
            else                        illegal = 1'b1;
        end else if (opcode_rs2ex == OPC_OP || opcode_rs2ex == OPC_OP_IMM) begin
            if (opcode_rs2ex == OPC_OP) begin
                if (funct7 == FUNCT7_ALT)
                    illegal = !(funct3_rs2ex == F3_ADD || funct3_rs2ex == F3_SR);
                else if (funct7 != FUNCT7_BASE)
                    illegal = 1'b1;
            end else if (funct3_rs2ex == F3_SLL) begin
                illegal = (imm_rs2ex[11:6] != 6'b000000);
            end else if (funct3_rs2ex == F3_SR) begin
                illegal = (imm_rs2ex[11:6] != 6'b000000) && (imm_rs2ex[11:6] != 6'b010000);
            end
            case (funct3_rs2ex)
                F3_ADD:  alu_res = (opcode_rs2ex == OPC_OP && imm_rs2ex[10])
                                   ? rs1_rs2ex - op_b : rs1_rs2ex + op_b;
                F3_SLL:  alu_res = rs1_rs2ex << shamt;
                F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(rs1_rs2ex) < $signed(op_b)};
                F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, rs1_rs2ex < op_b};
                F3_XOR:  alu_res = rs1_rs2ex ^ op_b;
                F3_SR:   alu_res = imm_rs2ex[10] ? $unsigned($signed(rs1_rs2ex) >>> shamt)
                                                 : rs1_rs2ex >> shamt;
                F3_OR:   alu_res = rs1_rs2ex | op_b;
                F3_AND:  alu_res = rs1_rs2ex & op_b;
                default: alu_res = '0;
            endcase
        end else begin
            illegal = 1'b1;
        end
    end

    // Next-state and output register: ALU results go out next cycle, MUL result on done.
    always_comb begin
        state_d   = state_q;
        valid_d   = 1'b0;
        result_d  = result_q;
        rd_d      = rd_q;
        tag_d     = tag_q;
        exc_d     = exc_q;
        mul_rd_d  = mul_rd_q;
        mul_tag_d = mul_tag_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d   = MUL;
                        mul_rd_d  = rd_rs2ex;
                        mul_tag_d = tag_rs2ex;
                    end else begin
                        valid_d  = 1'b1;
                        result_d = illegal ? '0 : alu_res;
                        rd_d     = rd_rs2ex;
                        tag_d    = tag_rs2ex;
                        exc_d    = illegal;
                    end
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_d  = IDLE;
                    valid_d  = 1'b1;
                    result_d = mul_product;
                    rd_d     = mul_rd_q;
                    tag_d    = mul_tag_q;
                    exc_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            result_q  <= '0;
            rd_q      <= '0;
            tag_q     <= '0;
            exc_q     <= 1'b0;
            mul_rd_q  <= '0;
            mul_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
            tag_q     <= tag_d;
            exc_q     <= exc_d;
            mul_rd_q  <= mul_rd_d;
            mul_tag_q <= mul_tag_d;
        end
    end

    int_mul_iter #(.XLEN(XLEN)) u_mul (
        .clk       (clk),
        .res       (res),
        .start_i   (accept && is_mul),
        .a_i       (rs1_rs2ex),
        .b_i       (rs2_rs2ex),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

endmodule
